// File: rtl/cnt_event_pkg.sv
// Shared constants for the timer event path: FSM encodings and the default
// widths shared with the upstream free-running counter.
package cnt_event_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_EVW   = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ARMED = 2'b01;
  localparam logic [1:0] ST_FIRED = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_FIRED = ST_FIRED
  } state_t;

endpackage

// File: rtl/cnt_wrap_detect.sv
// Registers the incoming count and pulses wrap_o one cycle after the count
// steps backwards (natural rollover or an upstream clear).
module cnt_wrap_detect
  import cnt_event_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q;

  // cnt_q starts at 0, so nothing can compare below it right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_i;
      wrap_o <= (cnt_i < cnt_q);
    end
  end

endmodule

// File: rtl/cnt_event_gen.sv
// Compare/wrap event generator for the timer subsystem: qualified match
// pulses, sticky interrupt, saturating event count and an arm/disarm FSM.
module cnt_event_gen
  import cnt_event_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               EVW     = DEF_EVW,
  parameter logic [WIDTH-1:0] CMP_RST = WIDTH'(8'hFF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] cmp_i,
  input  logic             cmp_load_i,
  input  logic             arm_i,
  input  logic             disarm_i,
  input  logic             periodic_i,
  input  logic             irq_ack_i,
  output logic             match_o,
  output logic             wrap_o,
  output logic             irq_o,
  output logic [EVW-1:0]   match_cnt_o,
  output logic [1:0]       state_o
);

  logic [WIDTH-1:0] cmp_reg;
  logic             eq;
  logic             eq_q;
  logic             raw_match;
  logic             qual_match;
  logic             mode_q;
  logic             mode_d;
  state_t           state_q;
  state_t           state_d;

  assign eq        = (cnt_i == cmp_reg);
  assign raw_match = eq & ~eq_q;
  // Disarm outranks a match arriving in the same cycle.
  assign qual_match = raw_match && (state_q == S_ARMED) && !disarm_i;
  assign state_o    = state_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          state_d = S_ARMED;
          mode_d  = periodic_i;
        end
      end
      S_ARMED: begin
        if (disarm_i) begin
          state_d = S_IDLE;
        end else if (raw_match && !mode_q) begin
          state_d = S_FIRED;
        end
      end
      S_FIRED: begin
        if (disarm_i) begin
          state_d = S_IDLE;
        end else if (arm_i) begin
          state_d = S_ARMED;
          mode_d  = periodic_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // irq_o is a level held high until an ack cycle with no new set;
  // a set in the same cycle as the ack wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_reg     <= CMP_RST;
      eq_q        <= 1'b0;
      match_o     <= 1'b0;
      irq_o       <= 1'b0;
      match_cnt_o <= '0;
    end else begin
      eq_q    <= eq;
      match_o <= qual_match;
      if (cmp_load_i) begin
        cmp_reg <= cmp_i;
      end
      if (qual_match) begin
        irq_o <= 1'b1;
      end else if (irq_ack_i) begin
        irq_o <= 1'b0;
      end
      if (qual_match && (match_cnt_o != '1)) begin
        match_cnt_o <= match_cnt_o + 1'b1;
      end
    end
  end

  cnt_wrap_detect #(
    .WIDTH(WIDTH)
  ) u_wrap (
    .clk   (clk),
    .reset (reset),
    .cnt_i (cnt_i),
    .wrap_o(wrap_o)
  );

endmodule

// File: tb/tb_cnt_event_gen.sv
// Directed bench for cnt_event_gen: the driver pushes the hand-computed
// post-edge output word per cycle; a monitor pops and compares.
module tb_cnt_event_gen;
  import cnt_event_pkg::*;

  localparam int W   = 8;
  localparam int EVW = 2;
  localparam int EW  = 4 + EVW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]   cnt_i, cmp_i;
  logic           cmp_load_i, arm_i, disarm_i, periodic_i, irq_ack_i;
  logic           match_o, wrap_o, irq_o;
  logic [EVW-1:0] match_cnt_o;
  logic [1:0]     state_o;

  cnt_event_gen #(
    .WIDTH  (W),
    .EVW    (EVW),
    .CMP_RST(8'hFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_i      (cnt_i),
    .cmp_i      (cmp_i),
    .cmp_load_i (cmp_load_i),
    .arm_i      (arm_i),
    .disarm_i   (disarm_i),
    .periodic_i (periodic_i),
    .irq_ack_i  (irq_ack_i),
    .match_o    (match_o),
    .wrap_o     (wrap_o),
    .irq_o      (irq_o),
    .match_cnt_o(match_cnt_o),
    .state_o    (state_o)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  string         name_q[$];

  // expected post-edge sticky values, updated by the test sequence
  logic           e_irq;
  logic [EVW-1:0] e_cnt;
  logic [1:0]     e_state;

  // control inputs for the next driven cycle (one-cycle requests)
  logic         p_ld, p_arm, p_dis, p_per, p_ack;
  logic [W-1:0] p_cv;

  logic [W-1:0]   c;
  logic [EVW-1:0] sat_exp [5];

  function automatic void chk(input string nm, input logic [EW-1:0] act,
                              input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got match/wrap/irq/cnt/state=%b expected=%b at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // driver: apply one cycle of inputs at the falling edge
  task automatic cyc(input logic [W-1:0] cv, input logic em, input logic ew,
                     input string nm);
    @(negedge clk);
    cnt_i      = cv;
    cmp_load_i = p_ld;
    cmp_i      = p_cv;
    arm_i      = p_arm;
    disarm_i   = p_dis;
    periodic_i = p_per;
    irq_ack_i  = p_ack;
    p_ld  = 1'b0;
    p_arm = 1'b0;
    p_dis = 1'b0;
    p_per = 1'b0;
    p_ack = 1'b0;
    exp_q.push_back({em, ew, e_irq, e_cnt, e_state});
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset", {match_o, wrap_o, irq_o, match_cnt_o, state_o}, '0);
    cnt_i = '0; cmp_i = '0; cmp_load_i = 1'b0; arm_i = 1'b0;
    disarm_i = 1'b0; periodic_i = 1'b0; irq_ack_i = 1'b0;
    e_irq = 1'b0; e_cnt = '0; e_state = ST_IDLE;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor
  always @(posedge clk) begin
    string         nm;
    logic [EW-1:0] ex;
    #1;
    if (!reset && exp_q.size() > 0) begin
      nm = name_q.pop_front();
      ex = exp_q.pop_front();
      chk(nm, {match_o, wrap_o, irq_o, match_cnt_o, state_o}, ex);
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout waiting for stimulus to complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    cnt_i = '0; cmp_i = '0; cmp_load_i = 1'b0; arm_i = 1'b0;
    disarm_i = 1'b0; periodic_i = 1'b0; irq_ack_i = 1'b0;
    p_ld = 1'b0; p_arm = 1'b0; p_dis = 1'b0; p_per = 1'b0; p_ack = 1'b0;
    p_cv = '0;
    e_irq = 1'b0; e_cnt = '0; e_state = ST_IDLE;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    do_reset();

    // one-shot at cmp=5, free-running count through one wrap
    p_ld = 1'b1; p_cv = 8'h05;
    cyc(8'h00, 1'b0, 1'b0, "os_load");
    p_arm = 1'b1; p_per = 1'b0; e_state = ST_ARMED;
    cyc(8'h01, 1'b0, 1'b0, "os_arm");
    for (int i = 2; i < 266; i++) begin
      c = W'(i);
      if (i == 5) begin
        e_irq = 1'b1; e_cnt = 2'd1; e_state = ST_FIRED;
      end
      cyc(c, (i == 5), (i == 256), "os_run");
    end
    p_ack = 1'b1; e_irq = 1'b0;
    cyc(8'h0A, 1'b0, 1'b0, "os_ack");

    // periodic at cmp=0: wrap and match coincide
    p_ld = 1'b1; p_cv = 8'h00; p_arm = 1'b1; p_per = 1'b1; e_state = ST_ARMED;
    cyc(8'h0B, 1'b0, 1'b0, "per_arm");
    cyc(8'hFE, 1'b0, 1'b0, "per_fe");
    cyc(8'hFF, 1'b0, 1'b0, "per_ff");
    e_irq = 1'b1; e_cnt = 2'd2;
    cyc(8'h00, 1'b1, 1'b1, "per_wrap1");
    for (int i = 1; i <= 256; i++) begin
      c = W'(i);
      if (i == 256) e_cnt = 2'd3;
      cyc(c, (i == 256), (i == 256), "per_run");
    end

    // disarm in the match cycle suppresses the match
    p_ack = 1'b1; e_irq = 1'b0;
    cyc(8'h05, 1'b0, 1'b0, "ack2");
    p_ld = 1'b1; p_cv = 8'h40;
    cyc(8'h06, 1'b0, 1'b0, "ld40");
    cyc(8'h3F, 1'b0, 1'b0, "pre40");
    p_dis = 1'b1; e_state = ST_IDLE;
    cyc(8'h40, 1'b0, 1'b0, "disarm_vs_match");

    // ack coinciding with a qualified match keeps irq set
    p_arm = 1'b1; p_per = 1'b1; e_state = ST_ARMED;
    cyc(8'h41, 1'b0, 1'b0, "rearm");
    cyc(8'h3F, 1'b0, 1'b1, "wrap_3f");
    p_ack = 1'b1; e_irq = 1'b1;
    cyc(8'h40, 1'b1, 1'b0, "ack_vs_match");

    // arm while armed must not relatch one-shot mode
    p_arm = 1'b1; p_per = 1'b0;
    cyc(8'h41, 1'b0, 1'b0, "arm_ignored");
    cyc(8'h3F, 1'b0, 1'b1, "wrap_3f_b");
    cyc(8'h40, 1'b1, 1'b0, "still_periodic");

    // compare load in the match cycle: old value matches, new one next
    p_ld = 1'b1; p_cv = 8'h10;
    cyc(8'h41, 1'b0, 1'b0, "ld10");
    cyc(8'h0F, 1'b0, 1'b1, "pre10");
    p_ld = 1'b1; p_cv = 8'h20;
    cyc(8'h10, 1'b1, 1'b0, "race_old_cmp");
    for (int i = 8'h11; i <= 8'h20; i++) begin
      c = W'(i);
      cyc(c, (i == 8'h20), 1'b0, "race_new_cmp");
    end

    // saturation of the 2-bit event counter, then a stalled count
    do_reset();
    p_ld = 1'b1; p_cv = 8'h30;
    cyc(8'h00, 1'b0, 1'b0, "sat_load");
    p_arm = 1'b1; p_per = 1'b1; e_state = ST_ARMED;
    cyc(8'h01, 1'b0, 1'b0, "sat_arm");
    for (int k = 0; k < 5; k++) begin
      cyc(8'h2F, 1'b0, (k != 0), "sat_pre");
      e_irq = 1'b1; e_cnt = sat_exp[k];
      cyc(8'h30, 1'b1, 1'b0, "sat_match");
    end
    cyc(8'h2F, 1'b0, 1'b1, "stall_pre");
    for (int k = 0; k < 4; k++) begin
      cyc(8'h30, (k == 0), 1'b0, "stall");
    end

    // async reset while armed with irq set and count saturated
    do_reset();
    repeat (3) @(negedge clk);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got %0d pending entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
